// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the cycle-counter width helper.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDU_OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // The counter must hold WIDTH itself, hence one bit more than clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// EX-stage to multiply/divide unit bus; the core drives the master side,
// the unit implements the slave side.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
) ();
  import mdu_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall_req;

  modport master (
    output start, op, a, b, flush, rd_req,
    input  hi, lo, busy, done, stall_req
  );

  modport slave (
    input  start, op, a, b, flush, rd_req,
    output hi, lo, busy, done, stall_req
  );

endinterface

// File: rtl/mdu_divider.sv
// Restoring-division step datapath on operand magnitudes: one quotient bit per step.
// quo_next/rem_next expose the result of the step in progress.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    if (trial[WIDTH+1]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO for the pipelined MIPS core.
// Optional MDU_EARLY_OUT_EN: multiply finishes once the remaining multiplier is zero.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input logic            clk,
  input logic            reset,
  mdu_iterative_if.slave bus
);

  localparam int CW         = cnt_width(WIDTH);
  localparam int MUL_CYCLES = WIDTH / MUL_STEP;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               signed_op;
  logic               muldiv_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   mplier_shift;
  logic               mul_last;
  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;

  assign accept    = bus.start & ~bus.flush;
  assign signed_op = (bus.op == MDU_OP_MULT) || (bus.op == MDU_OP_DIV);
  assign muldiv_op = (bus.op == MDU_OP_MULT) || (bus.op == MDU_OP_MULTU) ||
                     (bus.op == MDU_OP_DIV)  || (bus.op == MDU_OP_DIVU);
  assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign partial      = mcand_q * {{(2*WIDTH-MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};
  assign prod_step    = prod_q + partial;
  assign prod_fixed   = neg_res_q ? -prod_step : prod_step;
  assign mplier_shift = mplier_q >> MUL_STEP;

`ifdef MDU_EARLY_OUT_EN
  assign mul_last = (cnt_q == CW'(1)) || (mplier_shift == '0);
`else
  assign mul_last = (cnt_q == CW'(1));
`endif

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // The signed fix-up is folded into the last iteration, so HI/LO are already
  // updated while FIX presents the done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_load  = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q - CW'(1);
        if (mul_last) begin
          {hi_d, lo_d} = prod_fixed;
          state_d      = ST_FIX;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          lo_d    = neg_res_q ? -quo_next : quo_next;
          hi_d    = neg_rem_q ? -rem_next : rem_next;
          state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: ;
    endcase

    // A new accepted op overrides whatever the current state computed.
    if (accept) begin
      case (bus.op)
        MDU_OP_MULT, MDU_OP_MULTU: begin
          state_d   = ST_MUL;
          cnt_d     = CW'(MUL_CYCLES);
          mcand_d   = {{WIDTH{1'b0}}, a_mag};
          mplier_d  = b_mag;
          prod_d    = '0;
          neg_res_d = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = 1'b0;
          hi_d      = hi_q;
          lo_d      = lo_q;
          div_step  = 1'b0;
        end
        MDU_OP_DIV, MDU_OP_DIVU: begin
          state_d   = ST_DIV;
          cnt_d     = CW'(WIDTH);
          div_load  = 1'b1;
          div_step  = 1'b0;
          neg_res_d = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = signed_op & bus.a[WIDTH-1];
          hi_d      = hi_q;
          lo_d      = lo_q;
        end
        MDU_OP_MTHI: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          div_step = 1'b0;
          hi_d     = bus.a;
          lo_d     = lo_q;
        end
        MDU_OP_MTLO: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          div_step = 1'b0;
          hi_d     = hi_q;
          lo_d     = bus.a;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done      = (state_q == ST_FIX);
  assign bus.stall_req = bus.rd_req & (bus.busy | (accept & muldiv_op));

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at WIDTH=32, MUL_STEP=1
// (default build, MDU_EARLY_OUT_EN undefined).
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  mdu_iterative_if #(.WIDTH(32)) bus ();

  mdu_iterative #(
    .WIDTH    (32),
    .MUL_STEP (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0; bus.rd_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h want %h", bus.hi, 32'h0); else passed++;
    total++; if (bus.lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h want %h", bus.lo, 32'h0); else passed++;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_multu_latency();
    int bad;
    bus.start = 1'b1; bus.op = MDU_OP_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    #1;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL multu_busy_c0: got %b want 0", bus.busy); else passed++;
    tick();
    bus.start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      if (c == 16) begin
        total++; if (bus.lo !== 32'h0) $display("[TB] FAIL multu_lo_hold: got %h want %h", bus.lo, 32'h0); else passed++;
      end
      tick();
    end
    total++; if (bad !== 0) $display("[TB] FAIL multu_busy_window: got %0d bad cycles want 0", bad); else passed++;
    total++; if (bus.done !== 1'b1) $display("[TB] FAIL multu_done_c33: got %b want 1", bus.done); else passed++;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL multu_busy_c33: got %b want 0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi: got %h want %h", bus.hi, 32'hFFFFFFFE); else passed++;
    total++; if (bus.lo !== 32'h00000001) $display("[TB] FAIL multu_lo: got %h want %h", bus.lo, 32'h00000001); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("[TB] FAIL multu_done_pulse: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_mult_signed();
    int lat;
    run_op(MDU_OP_MULT, 32'hFFFFFFFD, 32'd7, lat);
    total++; if (lat !== 33) $display("[TB] FAIL mult_latency: got %0d want 33", lat); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("[TB] FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFEB) $display("[TB] FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFEB); else passed++;
    tick();
  endtask

  task automatic test_div_signed();
    int lat;
    run_op(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
    total++; if (lat !== 33) $display("[TB] FAIL div_latency: got %0d want 33", lat); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFD) $display("[TB] FAIL div_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("[TB] FAIL div_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); else passed++;
    tick();
  endtask

  task automatic test_divu_zero();
    int lat;
    run_op(MDU_OP_DIVU, 32'd5, 32'd0, lat);
    total++; if (lat !== 33) $display("[TB] FAIL divu0_latency: got %0d want 33", lat); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFF) $display("[TB] FAIL divu0_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); else passed++;
    total++; if (bus.hi !== 32'd5) $display("[TB] FAIL divu0_hi: got %h want %h", bus.hi, 32'd5); else passed++;
    tick();
  endtask

  task automatic test_div_overflow();
    int lat;
    run_op(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    total++; if (lat !== 33) $display("[TB] FAIL divovf_latency: got %0d want 33", lat); else passed++;
    total++; if (bus.lo !== 32'h80000000) $display("[TB] FAIL divovf_lo: got %h want %h", bus.lo, 32'h80000000); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL divovf_hi: got %h want %h", bus.hi, 32'h0); else passed++;
    tick();
  endtask

  task automatic test_stall();
    int stalls;
    bit seen;
    bus.rd_req = 1'b1;
    bus.start = 1'b1; bus.op = MDU_OP_MULTU; bus.a = 32'd3; bus.b = 32'd5;
    #1;
    stalls = (bus.stall_req === 1'b1) ? 1 : 0;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        total++; if (bus.stall_req !== 1'b0) $display("[TB] FAIL stall_done_cycle: got %b want 0", bus.stall_req); else passed++;
        total++; if (bus.lo !== 32'd15) $display("[TB] FAIL stall_lo: got %h want %h", bus.lo, 32'd15); else passed++;
        break;
      end
      if (bus.stall_req === 1'b1) stalls++;
      tick();
    end
    total++; if (seen !== 1'b1) $display("[TB] FAIL stall_done_seen: got %b want 1", seen); else passed++;
    total++; if (stalls !== 33) $display("[TB] FAIL stall_count: got %0d want 33", stalls); else passed++;
    tick();
    total++; if (bus.stall_req !== 1'b0) $display("[TB] FAIL stall_idle: got %b want 0", bus.stall_req); else passed++;
    bus.rd_req = 1'b0;
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    bus.start = 1'b1; bus.op = MDU_OP_MTHI; bus.a = 32'hDEAD;
    tick();
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL flush_mthi_hi: got %h want %h", bus.hi, 32'h0); else passed++;
    bus.op = MDU_OP_MULTU; bus.a = 32'd9; bus.b = 32'd9; bus.rd_req = 1'b1;
    #1;
    total++; if (bus.stall_req !== 1'b0) $display("[TB] FAIL flush_stall: got %b want 0", bus.stall_req); else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL flush_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.lo !== 32'd15) $display("[TB] FAIL flush_lo: got %h want %h", bus.lo, 32'd15); else passed++;
    bus.start = 1'b0; bus.flush = 1'b0; bus.rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_div();
    int dones;
    bus.start = 1'b1; bus.op = MDU_OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    total++; if (bus.busy !== 1'b1) $display("[TB] FAIL rstdiv_busy_before: got %b want 1", bus.busy); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.lo !== 32'h0) $display("[TB] FAIL rstdiv_lo: got %h want %h", bus.lo, 32'h0); else passed++;
    total++; if (bus.hi !== 32'h0) $display("[TB] FAIL rstdiv_hi: got %h want %h", bus.hi, 32'h0); else passed++;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL rstdiv_busy: got %b want 0", bus.busy); else passed++;
    #2;
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("[TB] FAIL rstdiv_no_done: got %0d pulses want 0", dones); else passed++;
    total++; if (bus.lo !== 32'h0) $display("[TB] FAIL rstdiv_lo_after: got %h want %h", bus.lo, 32'h0); else passed++;
  endtask

  task automatic test_mthi_abort();
    int dones;
    bus.start = 1'b1; bus.op = MDU_OP_MTLO; bus.a = 32'hCAFE;
    tick();
    bus.start = 1'b0;
    total++; if (bus.lo !== 32'hCAFE) $display("[TB] FAIL mtlo_lo: got %h want %h", bus.lo, 32'hCAFE); else passed++;
    total++; if (bus.done !== 1'b0) $display("[TB] FAIL mtlo_done: got %b want 0", bus.done); else passed++;
    bus.start = 1'b1; bus.op = MDU_OP_MULTU; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.start = 1'b1; bus.op = MDU_OP_MTHI; bus.a = 32'h1234;
    tick();
    bus.start = 1'b0;
    total++; if (bus.hi !== 32'h1234) $display("[TB] FAIL mthi_abort_hi: got %h want %h", bus.hi, 32'h1234); else passed++;
    total++; if (bus.lo !== 32'hCAFE) $display("[TB] FAIL mthi_abort_lo: got %h want %h", bus.lo, 32'hCAFE); else passed++;
    total++; if (bus.busy !== 1'b0) $display("[TB] FAIL mthi_abort_busy: got %b want 0", bus.busy); else passed++;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    total++; if (dones !== 0) $display("[TB] FAIL mthi_abort_no_done: got %0d pulses want 0", dones); else passed++;
    total++; if (bus.hi !== 32'h1234) $display("[TB] FAIL mthi_abort_hi_hold: got %h want %h", bus.hi, 32'h1234); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.start = 1'b1; bus.op = MDU_OP_MULTU; bus.a = 32'd2; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    run_op(MDU_OP_DIVU, 32'd100, 32'd7, lat);
    total++; if (lat !== 33) $display("[TB] FAIL b2b_latency: got %0d want 33", lat); else passed++;
    total++; if (bus.lo !== 32'd14) $display("[TB] FAIL b2b_lo: got %h want %h", bus.lo, 32'd14); else passed++;
    total++; if (bus.hi !== 32'd2) $display("[TB] FAIL b2b_hi: got %h want %h", bus.hi, 32'd2); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("[TB] FAIL b2b_single_done: got %b want 0", bus.done); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_multu_latency();
    test_mult_signed();
    test_div_signed();
    test_divu_zero();
    test_div_overflow();
    test_reset_mid_div();
    test_stall();
    test_flush();
    test_mthi_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
